// File: rtl/serial_sub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : serial_sub_pkg                                         |
// | Description : Shared constants for the bit-serial subtractor         |
// |               (state encoding and default operand width).            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package serial_sub_pkg;

  // Default operand/result width
  localparam int SS_WIDTH_DEFAULT = 8;

  // Control FSM state encoding
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_fa_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : serial_fa_cell                                         |
// | Description : 1-bit combinational full adder used as the serial      |
// |               datapath of serial_subtractor.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module serial_fa_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  // Sum and majority carry
  always_comb begin
    s_o    = x_i ^ y_i ^ cin_i;
    cout_o = (x_i & y_i) | (x_i & cin_i) | (y_i & cin_i);
  end

endmodule : serial_fa_cell
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : serial_subtractor                                      |
// | Description : LSB-first bit-serial subtractor, r = a + ~b + 1, with  |
// |               valid/ready handshake on input and output. Produces    |
// |               unsigned borrow and signed overflow flags.             |
// |               Optional macro SERIAL_SUBTRACTOR_SAT_EN saturates the  |
// |               result to the signed limit on overflow.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SS_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             borrow
);

  localparam int             CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SERIAL_SUBTRACTOR_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             asgn_q, asgn_d;
  logic             bsgn_q, bsgn_d;
  logic             ovf_q, ovf_d;
  logic             brw_q, brw_d;

  logic             fa_s;
  logic             fa_co;

  serial_fa_cell u_fa (
    .x_i    (sa_q[0]),
    .y_i    (sb_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_co)
  );

  // Next-state logic: capture operands, process one bit per RUN cycle, hold in DONE
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    asgn_d  = asgn_q;
    bsgn_d  = bsgn_q;
    ovf_d   = ovf_q;
    brw_d   = brw_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = ~b;
          carry_d = 1'b1;          // the +1 of the two's complement
          cnt_d   = '0;
          asgn_d  = a[WIDTH-1];
          bsgn_d  = b[WIDTH-1];
          ovf_d   = 1'b0;
          brw_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = fa_co;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // fa_s is the result MSB and fa_co the final carry on this cycle
          brw_d   = ~fa_co;
          ovf_d   = (asgn_q != bsgn_q) & (fa_s != asgn_q);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
          if ((asgn_q != bsgn_q) && (fa_s != asgn_q)) begin
            res_d = asgn_q ? SAT_MIN : SAT_MAX;
          end
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset; partial work is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b1;
      asgn_q  <= 1'b0;
      bsgn_q  <= 1'b0;
      ovf_q   <= 1'b0;
      brw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      asgn_q  <= asgn_d;
      bsgn_q  <= bsgn_d;
      ovf_q   <= ovf_d;
      brw_q   <= brw_d;
    end
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    result    = res_q;
    overflow  = ovf_q;
    borrow    = brw_q;
  end

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_serial_subtractor                                   |
// | Description : Directed self-checking bench for serial_subtractor.    |
// |               Honours SERIAL_SUBTRACTOR_SAT_EN for saturated results.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             borrow;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .borrow    (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid, returning edges counted after capture
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 30);
  endtask

  // One full transaction with immediate output acceptance
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] er, input logic eb, input logic eo);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    wait_done(n);
    check({tag, "_lat"}, n, 32'd8);
    check({tag, "_res"}, {24'd0, result}, {24'd0, er});
    check({tag, "_brw"}, {31'd0, borrow}, {31'd0, eb});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  logic [7:0] sat_7f;
  logic [7:0] sw_exp;

  initial begin
    int n;
    int seen;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    sat_7f = 8'h7F;
`else
    sat_7f = 8'h80;
`endif
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #1;
    check("rst_state", {27'd0, in_ready, out_valid, overflow, borrow, 1'b0},
          32'b10000);
    check("rst_res", {24'd0, result}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of RUN
    a = 8'h05; b = 8'h03; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_state", {30'd0, in_ready, out_valid}, 32'b10);
    check("midrst_res", {24'd0, result}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_noval", seen, 32'd0);
    check("midrst_rdy", {31'd0, in_ready}, 32'd1);
    run_op("after_rst", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

    // Directed vectors
    run_op("borrow",   8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op("ovf_pos",  8'h7F, 8'hFF, sat_7f, 1'b1, 1'b1);
    run_op("b_min",    8'h00, 8'h80, sat_7f, 1'b1, 1'b1);
    run_op("b_min_an", 8'hFF, 8'h80, 8'h7F, 1'b0, 1'b0);
    run_op("b_zero",   8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0);
    run_op("a_eq_b",   8'h33, 8'h33, 8'h00, 1'b0, 1'b0);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    run_op("ovf_neg",  8'h80, 8'h01, 8'h80, 1'b0, 1'b1);
`else
    run_op("ovf_neg",  8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
`endif

    // Backpressure with new operands waiting on the input
    a = 8'h10; b = 8'h01; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h20; b = 8'h10;           // in_valid stays high
    wait_done(n);
    check("bp_lat", n, 32'd8);
    seen = 0;
    repeat (5) begin
      if (!out_valid || in_ready || result !== 8'h0F) seen++;
      @(posedge clk); #1;
    end
    check("bp_hold", seen, 32'd0);
    check("bp_res", {24'd0, result}, 32'h0F);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle", {30'd0, out_valid, in_ready}, 32'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_cap2", {31'd0, in_ready}, 32'd0);
    wait_done(n);
    check("bp2_lat", n, 32'd8);
    check("bp2_res", {24'd0, result}, 32'h10);
    check("bp2_flags", {30'd0, borrow, overflow}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Sweep a = 0..9, b = 1
    for (int i = 0; i < 10; i++) begin
      sw_exp = 8'(i) - 8'd1;
      run_op($sformatf("sweep%0d", i), 8'(i), 8'h01, sw_exp, (i == 0), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_subtractor
`default_nettype wire
